// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
//   pipe_state_e   : multi-cycle occupancy FSM states
//   MC_LAT_DEFAULT : default EX latency of a multi-cycle op
//   cnt_w_for()    : minimum timer width able to hold a given latency
// Optional feature macro used by pipeline_ctrl: PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } pipe_state_e;

  localparam int MC_LAT_DEFAULT = 4;

  // Timer width needed for a multi-cycle latency; never below one bit.
  function automatic int cnt_w_for(input int lat);
    int w;
    w = $clog2(lat);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mc_timer.sv
// Saturating down-counter that times a multi-cycle EX op.
// Ports:
//   clk, rst   clock, synchronous active-high reset (cnt -> 0)
//   load       load load_val this cycle (wins over dec)
//   load_val   value loaded on load
//   dec        decrement by one; holds at zero
//   cnt        current count
//   done       cnt == 0
module mc_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (F, D, EX, MEM, WB).
// Merges load-use stall, EX branch redirect, multi-cycle EX ops and data
// memory wait into per-register enable/flush controls.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ld_use_stall        load-use hazard on the D-stage instruction
//   br_taken            EX instruction redirects the PC (level)
//   ex_mc               EX holds a multi-cycle op (level)
//   mem_req, mem_ready  MEM access request / completion
//   *_en, *_flush       per pipeline register enable / NOP insert
//   mc_busy             FSM is in MC_WAIT
// Optional (macro PIPE_CTRL_PERF_EN): stall_cycles, flush_events, mc_ops
//   32-bit wrapping performance counters.
// All control outputs are combinational from state and inputs.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LAT = MC_LAT_DEFAULT,
  parameter int CNT_W  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_use_stall,
  input  logic        br_taken,
  input  logic        ex_mc,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        fd_en,
  output logic        dex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        fd_flush,
  output logic        dex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        mc_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
  output logic [31:0] mc_ops
`endif
);

  pipe_state_e      state_q, state_d;
  logic             mem_hold;
  logic             mc_enter;
  logic             mc_done;
  logic [CNT_W-1:0] cnt;

  assign mem_hold = mem_req & ~mem_ready;
  // Entry is deferred while MEM holds, so the timer only starts once the
  // op is actually locked into EX.
  assign mc_enter = (state_q == RUN) & ex_mc & ~mem_hold;

  mc_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (mc_enter),
    .load_val (CNT_W'(MC_LAT - 2)),
    .dec      (state_q == MC_WAIT),
    .cnt      (cnt),
    .done     (mc_done)
  );

  // Occupancy FSM. The entry cycle plus MC_LAT-2 countdown cycles stall EX;
  // the release cycle lets EX advance, giving MC_LAT cycles in total.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mc_enter)             state_d = MC_WAIT;
      MC_WAIT: if (mc_done && !mem_hold) state_d = RUN;
      default:                           state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Priority mux. A branch is only acted on once nothing above it holds EX,
  // so the level br_taken naturally defers the flush to the advancing cycle.
  always_comb begin
    pc_en       = 1'b1;
    fd_en       = 1'b1;
    dex_en      = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    fd_flush    = 1'b0;
    dex_flush   = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (rst) begin
      // defaults: everything enabled, nothing flushed
    end else if (mem_hold) begin
      pc_en       = 1'b0;
      fd_en       = 1'b0;
      dex_en      = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      memwb_flush = 1'b1; // keep WB from retiring the same instruction twice
    end else if ((state_q == MC_WAIT && !mc_done) || (state_q == RUN && ex_mc)) begin
      pc_en       = 1'b0;
      fd_en       = 1'b0;
      dex_en      = 1'b0;
      exmem_en    = 1'b0;
      exmem_flush = 1'b1; // bubble into MEM while EX is busy
    end else if (br_taken) begin
      fd_flush    = 1'b1;
      dex_flush   = 1'b1; // also squashes any load-use stalled D instruction
    end else if (ld_use_stall) begin
      pc_en       = 1'b0;
      fd_en       = 1'b0;
      dex_flush   = 1'b1;
    end
  end

  assign mc_busy = ~rst & (state_q == MC_WAIT);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;
  logic [31:0] mc_ops_q,       mc_ops_d;

  // fd_flush has no source other than a taken branch.
  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, ~pc_en};
    flush_events_d = flush_events_q + {31'd0, fd_flush};
    mc_ops_d       = mc_ops_q       + {31'd0, mc_enter};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
      mc_ops_q       <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
      mc_ops_q       <= mc_ops_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
  assign mc_ops       = mc_ops_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (MC_LAT=4). Each step drives inputs on the
// falling edge and checks the combinational outputs 1ns later.
// Output vector order: {pc,fd,dex,exmem,memwb _en, fd,dex,exmem,memwb _flush, mc_busy}
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld_use_stall = 1'b0, br_taken = 1'b0, ex_mc = 1'b1;
  logic mem_req = 1'b1, mem_ready = 1'b0;
  logic pc_en, fd_en, dex_en, exmem_en, memwb_en;
  logic fd_flush, dex_flush, exmem_flush, memwb_flush, mc_busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_events, mc_ops;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MC_LAT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .ld_use_stall(ld_use_stall), .br_taken(br_taken), .ex_mc(ex_mc),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .fd_en(fd_en), .dex_en(dex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .fd_flush(fd_flush), .dex_flush(dex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .mc_busy(mc_busy)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events), .mc_ops(mc_ops)
`endif
  );

  logic [9:0] obs;
  assign obs = {pc_en, fd_en, dex_en, exmem_en, memwb_en,
                fd_flush, dex_flush, exmem_flush, memwb_flush, mc_busy};

  localparam logic [9:0] IDLE  = 10'b11111_0000_0;
  localparam logic [9:0] IDLEB = 10'b11111_0000_1; // release cycle, still busy
  localparam logic [9:0] MCS   = 10'b00001_0010_0; // multi-cycle entry stall
  localparam logic [9:0] MCSB  = 10'b00001_0010_1;
  localparam logic [9:0] MHB   = 10'b00000_0001_1; // mem hold in MC_WAIT
  localparam logic [9:0] MH    = 10'b00000_0001_0;
  localparam logic [9:0] BR    = 10'b11111_1100_0;
  localparam logic [9:0] LDU   = 10'b00111_0100_0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  // inputs: r, br, ld, mc, req, rdy
  task automatic cyc(input logic r, input logic b, input logic l, input logic m,
                     input logic rq, input logic rd, input logic [9:0] e, input string tag);
    @(negedge clk);
    rst = r; br_taken = b; ld_use_stall = l; ex_mc = m; mem_req = rq; mem_ready = rd;
    #1;
    chk(tag, {22'd0, obs}, {22'd0, e});
  endtask

  initial begin
    // reset with ex_mc and a pending memory hold
    #1;
    chk("rst0", {22'd0, obs}, {22'd0, IDLE});
    cyc(1, 0, 0, 1, 1, 0, IDLE, "rst1");
    cyc(0, 0, 0, 0, 0, 0, IDLE, "post_rst_run");

    // multi-cycle op, MC_LAT=4
    cyc(0, 0, 0, 1, 0, 0, MCS,   "mc_entry");
    cyc(0, 0, 0, 1, 0, 0, MCSB,  "mc_wait1");
    cyc(0, 0, 0, 1, 0, 0, MCSB,  "mc_wait2");
    cyc(0, 0, 0, 1, 0, 0, IDLEB, "mc_release");
    cyc(0, 0, 0, 0, 0, 0, IDLE,  "mc_back_run");

    // branch together with load-use
    cyc(0, 1, 1, 0, 0, 0, BR,   "br_ldu");
    cyc(0, 0, 0, 0, 0, 0, IDLE, "after_br");

`ifdef PIPE_CTRL_PERF_EN
    chk("perf_mc_ops", mc_ops, 32'd1);
    chk("perf_flush",  flush_events, 32'd1);
    chk("perf_stall",  stall_cycles, 32'd3);
`endif

    // lone load-use stall
    cyc(0, 0, 1, 0, 0, 0, LDU,  "ldu");
    cyc(0, 0, 0, 0, 0, 0, IDLE, "after_ldu");

    // mem_req with mem_ready: no hold
    cyc(0, 0, 0, 0, 1, 1, IDLE, "mem_req_ready");

    // memory hold outlasting the timer inside MC_WAIT
    cyc(0, 0, 0, 1, 0, 0, MCS, "mh_mc_entry");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1, 0, MHB, $sformatf("mh_hold%0d", i));
    cyc(0, 0, 0, 1, 1, 1, IDLEB, "mh_release");
    cyc(0, 0, 0, 0, 0, 0, IDLE,  "mh_back_run");

    // branch deferred under memory hold
    cyc(0, 1, 0, 0, 1, 0, MH,   "br_under_hold");
    cyc(0, 1, 0, 0, 1, 1, BR,   "br_after_hold");
    cyc(0, 0, 0, 0, 0, 0, IDLE, "br_hold_done");

    // reset in the middle of MC_WAIT
    cyc(0, 0, 0, 1, 0, 0, MCS,  "rmc_entry");
    cyc(0, 0, 0, 1, 0, 0, MCSB, "rmc_wait");
    cyc(1, 0, 0, 1, 0, 0, IDLE, "rmc_rst");
    cyc(0, 0, 0, 0, 0, 0, IDLE, "rmc_run");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
